// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall controller for the 5-stage MIPS pipeline: Tuse/Tnew data hazards,
// mult/div busy sequencing, and a saturating stall-cycle counter.
module hazard_stall_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs_D,
  input  logic [4:0]  rt_D,
  input  logic [1:0]  tuse_rs_D,
  input  logic [1:0]  tuse_rt_D,
  input  logic        md_use_D,
  input  logic [4:0]  a3_E,
  input  logic [1:0]  tnew_E,
  input  logic        md_start_E,
  input  logic        md_op_E,
  input  logic [4:0]  a3_M,
  input  logic [1:0]  tnew_M,
  output logic        pcenable,
  output logic        d_enable,
  output logic        e_flush,
  output logic        md_busy,
  output logic [31:0] stall_cnt
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             stall_rs;
  logic             stall_rt;
  logic             stall_md;
  logic             stall;

  // A source operand stalls only if a later-stage producer targets it and the
  // result arrives after the operand is needed; $0 is hardwired and never waits.
  always_comb begin
    stall_rs = (rs_D != 5'd0) &&
               (((rs_D == a3_E) && (tuse_rs_D < tnew_E)) ||
                ((rs_D == a3_M) && (tuse_rs_D < tnew_M)));
    stall_rt = (rt_D != 5'd0) &&
               (((rt_D == a3_E) && (tuse_rt_D < tnew_E)) ||
                ((rt_D == a3_M) && (tuse_rt_D < tnew_M)));
    stall_md = md_use_D && (md_busy || md_start_E);
    stall    = stall_rs | stall_rt | stall_md;
  end

  assign pcenable = ~stall;
  assign d_enable = ~stall;
  assign e_flush  = stall;
  assign md_busy  = (state == BUSY);

  // Busy sequencer: a start while already busy is ignored (no reload).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (md_start_E) begin
            cnt   <= md_op_E ? DIV_LD : MULT_LD;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == ONE) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt - ONE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= 32'd0;
    end else if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  // The D-stage md stall should make a start during BUSY impossible.
  md_start_while_busy: assert property (@(posedge clk) disable iff (!reset)
    (md_busy |-> !md_start_E));

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: data hazards, $0 exemption, mult/div
// sequencing, asynchronous reset mid-BUSY and stall-counter saturation.
module tb_hazard_stall_ctrl;

  logic        clk;
  logic        reset;
  logic [4:0]  rs_D, rt_D, a3_E, a3_M;
  logic [1:0]  tuse_rs_D, tuse_rt_D, tnew_E, tnew_M;
  logic        md_use_D, md_start_E, md_op_E;
  logic        pcenable, d_enable, e_flush, md_busy;
  logic [31:0] stall_cnt;

  int checks   = 0;
  int failures = 0;
  logic [0:0] exp_q[$];

  hazard_stall_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .rs_D(rs_D), .rt_D(rt_D), .tuse_rs_D(tuse_rs_D), .tuse_rt_D(tuse_rt_D),
    .md_use_D(md_use_D), .a3_E(a3_E), .tnew_E(tnew_E),
    .md_start_E(md_start_E), .md_op_E(md_op_E),
    .a3_M(a3_M), .tnew_M(tnew_M),
    .pcenable(pcenable), .d_enable(d_enable), .e_flush(e_flush),
    .md_busy(md_busy), .stall_cnt(stall_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive_idle();
    rs_D = 5'd0; rt_D = 5'd0; tuse_rs_D = 2'd3; tuse_rt_D = 2'd3;
    md_use_D = 1'b0; a3_E = 5'd0; tnew_E = 2'd0;
    md_start_E = 1'b0; md_op_E = 1'b0; a3_M = 5'd0; tnew_M = 2'd0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive_idle();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic check_stall(input string tag, input logic exp_stall);
    check({tag, "_pcen"}, 32'(pcenable), 32'(!exp_stall));
    check({tag, "_den"},  32'(d_enable), 32'(!exp_stall));
    check({tag, "_flush"}, 32'(e_flush), 32'(exp_stall));
  endtask

  initial begin
    drive_idle();
    reset = 1'b0;
    #2;
    check("rst_busy", 32'(md_busy), 32'd0);
    check("rst_cnt", stall_cnt, 32'd0);
    check_stall("rst", 1'b0);
    @(negedge clk);
    reset = 1'b1;

    // 1. load-use on rs, then resolved when producer is in M
    @(negedge clk);
    a3_E = 5'd8; tnew_E = 2'd2; rs_D = 5'd8; tuse_rs_D = 2'd1;
    #1 check_stall("lu_e", 1'b1);
    @(negedge clk);
    a3_E = 5'd0; tnew_E = 2'd0; a3_M = 5'd8; tnew_M = 2'd1;
    #1 check_stall("lu_m", 1'b0);
    check("lu_cnt", stall_cnt, 32'd1);
    // rt hazard from M, then simultaneous rs(E)+rt(M) counts once
    @(negedge clk);
    drive_idle();
    rt_D = 5'd9; tuse_rt_D = 2'd0; a3_M = 5'd9; tnew_M = 2'd1;
    #1 check_stall("rt_m", 1'b1);
    @(negedge clk);
    rs_D = 5'd8; tuse_rs_D = 2'd1; a3_E = 5'd8; tnew_E = 2'd2;
    #1 check_stall("both", 1'b1);
    @(negedge clk);
    drive_idle();
    #1 check("both_cnt", stall_cnt, 32'd3);

    // 2. $0 exemption and tuse == tnew boundary
    @(negedge clk);
    rs_D = 5'd0; a3_E = 5'd0; tnew_E = 2'd2; tuse_rs_D = 2'd0;
    rt_D = 5'd0; a3_M = 5'd0; tnew_M = 2'd2; tuse_rt_D = 2'd0;
    #1 check_stall("zero", 1'b0);
    @(negedge clk);
    drive_idle();
    rs_D = 5'd5; a3_E = 5'd5; tuse_rs_D = 2'd2; tnew_E = 2'd2;
    #1 check_stall("tuse_eq", 1'b0);
    @(negedge clk);
    #1 check("zero_cnt", stall_cnt, 32'd3);

    // 3. mult with mflo held in D
    do_reset();
    md_start_E = 1'b1; md_op_E = 1'b0; md_use_D = 1'b1;
    #1 check("mul_start_busy", 32'(md_busy), 32'd0);
    check_stall("mul_start", 1'b1);
    for (int i = 0; i < 5; i++) exp_q.push_back(1'b1);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 6; i++) begin
      logic [0:0] e;
      @(negedge clk);
      md_start_E = 1'b0;
      #1 e = exp_q.pop_front();
      check($sformatf("mul_busy%0d", i), 32'(md_busy), 32'(e));
      check_stall($sformatf("mul_st%0d", i), e[0]);
    end
    check("mul_cnt", stall_cnt, 32'd6);

    // 4. div with unrelated addu in D
    do_reset();
    md_start_E = 1'b1; md_op_E = 1'b1;
    rs_D = 5'd3; rt_D = 5'd4; tuse_rs_D = 2'd1; tuse_rt_D = 2'd1;
    #1 check_stall("div_start", 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      md_start_E = 1'b0;
      #1 check($sformatf("div_busy%0d", i), 32'(md_busy), 32'd1);
      check($sformatf("div_pcen%0d", i), 32'(pcenable), 32'd1);
    end
    @(negedge clk);
    #1 check("div_done", 32'(md_busy), 32'd0);
    check("div_cnt", stall_cnt, 32'd0);

    // 5. asynchronous reset three cycles into a div
    do_reset();
    md_start_E = 1'b1; md_op_E = 1'b1; md_use_D = 1'b1;
    @(negedge clk);
    md_start_E = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 check("rb_busy_pre", 32'(md_busy), 32'd1);
    check("rb_cnt_pre", stall_cnt, 32'd3);
    #1 reset = 1'b0;
    #1 check("rb_busy", 32'(md_busy), 32'd0);
    check("rb_cnt", stall_cnt, 32'd0);
    check_stall("rb", 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1 check_stall("rb_rel", 1'b0);
    @(negedge clk);
    #1 check("rb_rel_busy", 32'(md_busy), 32'd0);
    check("rb_rel_cnt", stall_cnt, 32'd0);

    // 6. saturation of the stall counter
    do_reset();
    a3_E = 5'd8; tnew_E = 2'd2; rs_D = 5'd8; tuse_rs_D = 2'd1;
    force dut.stall_cnt = 32'hFFFF_FFFE;
    @(negedge clk);
    release dut.stall_cnt;
    @(negedge clk);
    @(negedge clk);
    #1 check("sat", stall_cnt, 32'hFFFF_FFFF);
    @(negedge clk);
    #1 check("sat_hold", stall_cnt, 32'hFFFF_FFFF);
    drive_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
